// File: rtl/pt_check.sv
`default_nettype none
// ============================================================================
// Module      : pt_check
// Description : Scans a length-prefixed plaintext buffer and reports whether
//               every message byte lies in the printable range [LO, HI].
// Revision    : 1.0 - initial release
// ============================================================================
module pt_check #(
    parameter logic [7:0] LO = 8'h20,
    parameter logic [7:0] HI = 8'h7E
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] pt_addr,
    input  logic [7:0] pt_rddata,
    output logic       valid,
    output logic [7:0] bad_idx
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_LEN = 2'd1,
        S_GET_LEN  = 2'd2,
        S_CHECK    = 2'd3
    } state_t;

    state_t     r_state;
    logic [7:0] r_len;
    logic [7:0] r_idx;
    logic       w_in_range;

    assign w_in_range = (pt_rddata >= LO) && (pt_rddata <= HI);

    // pt_addr runs two cycles ahead of the byte being judged because of the
    // registered address plus the one-cycle RAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            rdy     <= 1'b0;
            valid   <= 1'b0;
            bad_idx <= 8'd0;
            pt_addr <= 8'd0;
            r_len   <= 8'd0;
            r_idx   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!rdy) begin
                        rdy <= 1'b1;
                    end else if (en) begin
                        rdy     <= 1'b0;
                        valid   <= 1'b0;
                        bad_idx <= 8'd0;
                        pt_addr <= 8'd0;
                        r_state <= S_WAIT_LEN;
                    end
                end
                S_WAIT_LEN: begin
                    pt_addr <= 8'd1;
                    r_state <= S_GET_LEN;
                end
                S_GET_LEN: begin
                    r_len   <= pt_rddata;
                    r_idx   <= 8'd1;
                    pt_addr <= 8'd2;
                    if (pt_rddata == 8'd0) begin
                        valid   <= 1'b1;
                        rdy     <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!w_in_range) begin
                        valid   <= 1'b0;
                        bad_idx <= r_idx;
                        rdy     <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_idx == r_len) begin
                        valid   <= 1'b1;
                        bad_idx <= 8'd0;
                        rdy     <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx   <= r_idx + 8'd1;
                        pt_addr <= pt_addr + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/pt_check.md
Name: pt_check

Overview:
- Reader-side consumer of the plaintext memory that `prga` writes in the cracking datapath.
- Operates on a length-prefixed plaintext buffer: byte 0 holds the length L, bytes 1..L hold the message.
- Scans bytes 1..L and reports whether every byte lies in the printable range [LO, HI].
- The crack controller uses the verdict to accept or reject the current candidate key; the block aborts on the first non-printable byte to save cycles.

Parameters:
LO  8'h20  lowest accepted byte value, inclusive
HI  8'h7E  highest accepted byte value, inclusive

Ports:
clk        input   1  clock; all state changes on the rising edge
rst        input   1  synchronous reset, active-high
en         input   1  start request; honoured only in a cycle where rdy=1
rdy        output  1  high = idle and able to accept en
pt_addr    output  8  plaintext memory read address, registered
pt_rddata  input   8  plaintext memory read data; synchronous RAM with one-cycle read latency
valid      output  1  result of last scan: 1 = all bytes 1..L printable, including L=0
bad_idx    output  8  index of the first failing byte in the last scan; 0 when valid=1

Behaviour:
- Memory timing: pt_addr registered at edge Ek is sampled by the RAM at Ek+1. Its data appears on pt_rddata after Ek+1 and is consumed by the block at Ek+2.
- Reset (rst=1 at an edge): state=IDLE, rdy=0, valid=0, bad_idx=0, pt_addr=0, internal len/idx=0.
- First edge with rst=0: rdy<=1.
- Reset mid-scan aborts immediately; no result is produced; valid and bad_idx are cleared.
- IDLE, rdy=1, en=1 at edge E0:
  - rdy<=0, valid<=0, bad_idx<=0, pt_addr<=0.
  - Go to WAIT_LEN.
- en with rdy=0 is ignored.
- en held high across the return to IDLE starts a new scan on the first edge where rdy=1.
- WAIT_LEN (E1): pt_addr<=1; go to GET_LEN.
- GET_LEN (E2):
  - len<=pt_rddata, idx<=1, pt_addr<=2.
  - If pt_rddata==0: valid<=1, rdy<=1, go to IDLE. Result is visible after E2.
  - Otherwise go to CHECK.
- CHECK (edge E_idx+2): pt_rddata holds byte idx.
  - Out of range (pt_rddata<LO or pt_rddata>HI): valid<=0, bad_idx<=idx, rdy<=1, go to IDLE.
  - In range and idx==len: valid<=1, bad_idx<=0, rdy<=1, go to IDLE.
  - Otherwise: idx<=idx+1, pt_addr<=pt_addr+1. Throughput is one byte per cycle.
- Latency from accept edge E0:
  - All bytes pass: rdy rises after edge E(L+2).
  - Failure at index k: rdy rises after edge E(k+2).
- Result hold: valid and bad_idx remain stable while rdy=1, until the next accepted en clears them.
- Width rules:
  - pt_addr is 8-bit and wraps mod 256. When L=255 it reaches 256->0; the over-read beyond L is harmless and its data is never used.
  - idx and len are 8-bit; idx never exceeds len.
- Range comparisons are unsigned; LO and HI themselves pass.
- No writes are issued; the block never drives write enable or data toward the plaintext memory.

Test Plan:
- Reset held 3 cycles, then released. Required: rdy=0 during reset, rdy=1 on the first edge after release, valid=0, bad_idx=0.
- Memory {8'h05,"Hello"}, pulse en. Required: pt_addr sequence 0,1,2,..,6; valid=1; bad_idx=0; rdy rises after E7 (L+2 edges after accept).
- Memory {8'h04,8'h41,8'h42,8'h0A,8'h43}. Required: valid=0, bad_idx=3, rdy rises after E5, and no check of byte 4.
- Boundary bytes {8'h03,8'h20,8'h7E,8'h7F}. Required: valid=0, bad_idx=3.
- Boundary bytes {8'h02,8'h1F,8'h20}. Required: valid=0, bad_idx=1.
- L=0. Required: valid=1, rdy after E2.
- L=255, all 8'h61. Required: valid=1 and pt_addr wraps to 0 without error.
- Assert rst mid-scan at E4 of the "Hello" run. Required: rdy=0, valid=0 during reset; rdy=1 on the next edge with rst=0; a fresh en rescans and reports valid=1.
- Also in the rst mid-scan run: en pulsed while rdy=0 has no effect.
